display_formatter: RTL and testbench

- Producer side of the 7-segment digit-code interface. Its outputs drive the existing BCD-to-segment decoder.
- Converts a 14-bit binary reading (distance, time, speed or cadence) into four BCD digits. Conversion is sequential (double-dabble, one bit per clock).
- Time-multiplexes the four digits onto one 4-bit code bus with a one-hot digit enable.
- Digit code map:
  - 0-9: numerals.
  - 10/11/12/13: letters d/t/v/c.
  - 14: blank.
  - 15: error glyph "E".

---
 rtl/cycle_display_pkg.sv | 34 +++
 rtl/bin2bcd_seq.sv | 51 +++++
 rtl/display_formatter.sv | 148 ++++++++++++++
 tb/tb_display_formatter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cycle_display_pkg.sv
// Shared types and code constants for the cycle-computer display path.
// Digit codes 0-9 are numerals; the constants below cover letters, blank and error.
package cycle_display_pkg;

    typedef logic [3:0] digit_code_t;

    typedef enum logic [1:0] {
        MODE_DIST    = 2'd0,
        MODE_TIME    = 2'd1,
        MODE_SPEED   = 2'd2,
        MODE_CADENCE = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } fmt_state_t;

    localparam digit_code_t CODE_D     = 4'd10;
    localparam digit_code_t CODE_T     = 4'd11;
    localparam digit_code_t CODE_V     = 4'd12;
    localparam digit_code_t CODE_C     = 4'd13;
    localparam digit_code_t CODE_BLANK = 4'd14;
    localparam digit_code_t CODE_ERR   = 4'd15;

    localparam int MAX_DISPLAY = 9999;

    // Letter codes d/t/v/c are laid out in mode order.
    function automatic digit_code_t mode_letter(input mode_t m);
        return CODE_D + digit_code_t'(m);
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble engine: 14-bit binary to four BCD nibbles, one bit per clock.
// done is high during the last shift cycle; bcd holds its result until the next start.
module bin2bcd_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [13:0] bin,
    output logic        busy,
    output logic        done,
    output logic [15:0] bcd
);

    logic [13:0] shreg;
    logic [3:0]  cnt;
    logic        active;
    logic [15:0] adj;

    always_comb begin
        adj = bcd;
        for (int i = 0; i < 4; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shreg  <= '0;
            cnt    <= '0;
            active <= 1'b0;
            bcd    <= '0;
        end else if (start && !active) begin
            shreg  <= bin;
            cnt    <= 4'd14;
            active <= 1'b1;
            bcd    <= '0;
        end else if (active) begin
            bcd   <= {adj[14:0], shreg[13]};
            shreg <= {shreg[12:0], 1'b0};
            cnt   <= cnt - 4'd1;
            if (cnt == 4'd1) begin
                active <= 1'b0;
            end
        end
    end

    assign busy = active;
    assign done = active && (cnt == 4'd1);

endmodule

// File: rtl/display_formatter.sv
// Converts a binary reading to four display codes and scans them onto one digit-code bus.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zeros above the units digit at commit.
module display_formatter
    import cycle_display_pkg::*;
#(
    parameter int SCAN_DIV = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [13:0] value,
    input  logic [1:0]  mode,
    input  logic        mode_show,
    output logic        busy,
    output logic        done,
    output logic [3:0]  bcd_out,
    output logic [3:0]  digit_en
);

    localparam int PW = $clog2(SCAN_DIV);

    fmt_state_t  state, state_next;
    logic        start, eng_done;
    logic [15:0] bcd;
    mode_t       mode_q;
    logic        show_q, over_q;
    digit_code_t new_digits [4];
    digit_code_t disp [4];
    logic [PW-1:0] presc;
    logic [1:0]  idx, idx_next;
    logic        tc;

    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .bin   (value),
        .busy  (busy),
        .done  (eng_done),
        .bcd   (bcd)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Loads are only accepted in IDLE, so loads during SHIFT or COMMIT are dropped.
    always_comb begin
        state_next = state;
        start      = 1'b0;
        done       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (load) begin
                    start      = 1'b1;
                    state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (eng_done) begin
                    state_next = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q <= MODE_DIST;
            show_q <= 1'b0;
            over_q <= 1'b0;
        end else if (start) begin
            mode_q <= mode_t'(mode);
            show_q <= mode_show;
            over_q <= (value > 14'(MAX_DISPLAY));
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic lead3, lead2, lead1;

    // A mode letter occupies digit 3, so zeros below it still count as leading.
    always_comb begin
        lead3 = !show_q && (bcd[15:12] == 4'd0);
        lead2 = (show_q || lead3) && (bcd[11:8] == 4'd0);
        lead1 = lead2 && (bcd[7:4] == 4'd0);
    end
`endif

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            new_digits[i] = bcd[4*i +: 4];
        end
`ifdef LEADING_ZERO_BLANK_EN
        if (lead3) new_digits[3] = CODE_BLANK;
        if (lead2) new_digits[2] = CODE_BLANK;
        if (lead1) new_digits[1] = CODE_BLANK;
`endif
        if (show_q) begin
            new_digits[3] = mode_letter(mode_q);
        end
        if (over_q) begin
            for (int i = 0; i < 4; i++) begin
                new_digits[i] = CODE_ERR;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                disp[i] <= CODE_BLANK;
            end
        end else if (done) begin
            for (int i = 0; i < 4; i++) begin
                disp[i] <= new_digits[i];
            end
        end
    end

    assign tc       = (presc == PW'(SCAN_DIV - 1));
    assign idx_next = tc ? idx + 2'd1 : idx;

    // Commit data bypasses the display registers so new codes show one cycle after COMMIT.
    always_ff @(posedge clk) begin
        if (reset) begin
            presc    <= '0;
            idx      <= 2'd0;
            digit_en <= 4'b0001;
            bcd_out  <= CODE_BLANK;
        end else begin
            presc    <= tc ? '0 : presc + PW'(1);
            idx      <= idx_next;
            digit_en <= 4'b0001 << idx_next;
            bcd_out  <= done ? new_digits[idx_next] : disp[idx_next];
        end
    end

endmodule

// File: tb/tb_display_formatter.sv
// Randomized self-checking bench for display_formatter with a fast scan (SCAN_DIV=4).
// Expected digits come from decimal arithmetic on the loaded value, not from the RTL structure.
module tb_display_formatter;

    localparam logic [20:0] BUSY_PROFILE = 21'h007FFE;
    localparam logic [20:0] DONE_PROFILE = 21'h008000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load = 1'b0;
    logic [13:0] value = '0;
    logic [1:0]  mode = '0;
    logic        mode_show = 1'b0;
    logic        busy, done;
    logic [3:0]  bcd_out, digit_en;

    int compared = 0;
    int mismatched = 0;
    logic [15:0] disp_model;

    always #5 clk = ~clk;

    display_formatter #(.SCAN_DIV(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .value     (value),
        .mode      (mode),
        .mode_show (mode_show),
        .busy      (busy),
        .done      (done),
        .bcd_out   (bcd_out),
        .digit_en  (digit_en)
    );

    // Decimal reference: split the reading into digits, then apply letter/blank/error rules.
    function automatic logic [15:0] expect_digits(input int v, input int m, input bit show);
        int d [4];
        int num;
        logic [15:0] r;
        if (v > 9999) return 16'hFFFF;
        d[0] = v % 10;
        d[1] = (v / 10) % 10;
        d[2] = (v / 100) % 10;
        d[3] = v / 1000;
        num = show ? v % 1000 : v;
`ifdef LEADING_ZERO_BLANK_EN
        if (num < 1000) d[3] = 14;
        if (num < 100)  d[2] = 14;
        if (num < 10)   d[1] = 14;
`endif
        if (show) d[3] = 10 + m;
        for (int i = 0; i < 4; i++) r[4*i +: 4] = 4'(d[i]);
        return r;
    endfunction

    function automatic logic [3:0] digit_at(input logic [15:0] d, input logic [3:0] en);
        for (int i = 0; i < 4; i++) begin
            if (en == (4'b0001 << i)) return d[4*i +: 4];
        end
        return 4'hx;
    endfunction

    task automatic sample_display(output logic [15:0] seen, output bit coherent);
        seen = 16'hxxxx;
        coherent = 1'b1;
        repeat (18) begin
            @(negedge clk);
            if (!$onehot(digit_en)) coherent = 1'b0;
            for (int i = 0; i < 4; i++) begin
                if (digit_en[i]) seen[4*i +: 4] = bcd_out;
            end
        end
    endtask

    task automatic drive_load(input bit immediate, input int v, input int m, input bit show,
                              input int extra_at, input int extra_v,
                              output logic [20:0] bm, output logic [20:0] dm,
                              output logic [3:0] e15, output logic [3:0] b15,
                              output logic [3:0] e16, output logic [3:0] b16);
        if (!immediate) @(negedge clk);
        value = 14'(v);
        mode = 2'(m);
        mode_show = show;
        load = 1'b1;
        bm = '0;
        dm = '0;
        e15 = '0; b15 = '0; e16 = '0; b16 = '0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            load = 1'b0;
            bm[k] = busy;
            dm[k] = done;
            if (k == 15) begin e15 = digit_en; b15 = bcd_out; end
            if (k == 16) begin e16 = digit_en; b16 = bcd_out; end
            if (k == extra_at) begin
                value = 14'(extra_v);
                mode_show = 1'b0;
                load = 1'b1;
            end
        end
        load = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] want_en;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        compared++;
        if (digit_en !== 4'b0001 || bcd_out !== 4'd14 || busy !== 1'b0 || done !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_state: got en=%b code=%0d busy=%b done=%b want en=0001 code=14 busy=0 done=0",
                     digit_en, bcd_out, busy, done);
        end
        reset = 1'b0;
        disp_model = 16'hEEEE;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            want_en = 4'b0001 << ((c / 4) % 4);
            compared++;
            if (digit_en !== want_en || bcd_out !== 4'd14) begin
                mismatched++;
                $display("[TB] FAIL scan_step c=%0d: got en=%b code=%0d want en=%b code=14",
                         c, digit_en, bcd_out, want_en);
            end
        end
    endtask

    task automatic test_conversion(input string name, input bit immediate, input int v, input int m,
                                   input bit show, input int extra_at, input int extra_v);
        logic [20:0] bm, dm;
        logic [3:0] e15, b15, e16, b16;
        logic [15:0] exp_new, seen;
        bit coh;
        exp_new = expect_digits(v, m, show);
        drive_load(immediate, v, m, show, extra_at, extra_v, bm, dm, e15, b15, e16, b16);
        compared++;
        if (bm !== BUSY_PROFILE) begin
            mismatched++;
            $display("[TB] FAIL %s busy_profile: got %h want %h", name, bm, BUSY_PROFILE);
        end
        compared++;
        if (dm !== DONE_PROFILE) begin
            mismatched++;
            $display("[TB] FAIL %s done_profile: got %h want %h", name, dm, DONE_PROFILE);
        end
        compared++;
        if (b15 !== digit_at(disp_model, e15)) begin
            mismatched++;
            $display("[TB] FAIL %s old_visible: got %0d want %0d (en=%b)", name, b15, digit_at(disp_model, e15), e15);
        end
        compared++;
        if (b16 !== digit_at(exp_new, e16)) begin
            mismatched++;
            $display("[TB] FAIL %s new_visible: got %0d want %0d (en=%b)", name, b16, digit_at(exp_new, e16), e16);
        end
        disp_model = exp_new;
        sample_display(seen, coh);
        compared++;
        if (coh !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL %s onehot_scan: got %b want 1", name, coh);
        end
        compared++;
        if (seen !== exp_new) begin
            mismatched++;
            $display("[TB] FAIL %s digits: got %h want %h (v=%0d m=%0d show=%0d)", name, seen, exp_new, v, m, show);
        end
    endtask

    task automatic test_over_range();
        test_conversion("over_10000", 1'b0, 10000, 0, 1'b0, 0, 0);
        test_conversion("zero", 1'b0, 0, 1, 1'b0, 0, 0);
        test_conversion("over_max", 1'b0, 16383, 3, 1'b1, 0, 0);
        test_conversion("max_legal", 1'b0, 9999, 0, 1'b0, 0, 0);
    endtask

    task automatic test_back_to_back();
        test_conversion("load_while_busy", 1'b0, 5555, 0, 1'b0, 5, 1111);
        test_conversion("load_in_commit", 1'b0, 321, 1, 1'b0, 15, 77);
    endtask

    task automatic test_reset_abort();
        int done_seen, busy_seen;
        logic [15:0] seen;
        bit coh;
        done_seen = 0;
        busy_seen = 0;
        @(negedge clk);
        value = 14'd4321; mode = 2'd0; mode_show = 1'b0; load = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            load = 1'b0;
            done_seen += int'(done);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        disp_model = 16'hEEEE;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            done_seen += int'(done);
            busy_seen += int'(busy);
        end
        compared++;
        if (done_seen != 0 || busy_seen != 0) begin
            mismatched++;
            $display("[TB] FAIL abort_quiet: got done=%0d busy=%0d cycles want 0 and 0", done_seen, busy_seen);
        end
        sample_display(seen, coh);
        compared++;
        if (seen !== 16'hEEEE) begin
            mismatched++;
            $display("[TB] FAIL abort_blank: got %h want eeee", seen);
        end
        @(negedge clk);
        value = 14'd8765; load = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            load = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        test_conversion("load_after_reset", 1'b1, 2468, 2, 1'b0, 0, 0);
    endtask

    task automatic test_random();
        int v, m;
        bit show;
        for (int i = 0; i < 8; i++) begin
            v = $urandom_range(0, 11000);
            m = $urandom_range(0, 3);
            show = 1'($urandom_range(0, 1));
            test_conversion("random", 1'b0, v, m, show, 0, 0);
        end
    endtask

    initial begin
        test_reset();
        test_conversion("basic_1234", 1'b0, 1234, 0, 1'b0, 0, 0);
        test_conversion("mode_letter", 1'b0, 987, 2, 1'b1, 0, 0);
        test_over_range();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
